// File: rtl/ring_fifo_pkg.sv
// ring_fifo_pkg -- shared constants and sizing helpers for ring_fifo | rev 1.0
`default_nettype none

package ring_fifo_pkg;

  localparam int unsigned c_data_w = 8;
  localparam int unsigned c_addr_w = 4;

  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Pointers and occupancy carry one extra bit so full and empty stay distinct.
  function automatic int unsigned ptr_width(input int unsigned addr_w);
    return addr_w + 32'd1;
  endfunction

  localparam int unsigned c_depth = fifo_depth(c_addr_w);
  localparam int unsigned c_ptr_w = ptr_width(c_addr_w);

endpackage

`default_nettype wire

// File: rtl/ring_fifo_if.sv
// ring_fifo_if -- data/handshake/status bundle; almost_full only with RING_FIFO_AFULL_EN | rev 1.0
`default_nettype none

interface ring_fifo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic [DATA_W-1:0] in;
  logic              wen;
  logic              ren;
  logic              clr_err;
  logic [DATA_W-1:0] out;
  logic              available;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
`ifdef RING_FIFO_AFULL_EN
  logic              almost_full;
`endif

  modport master (
    output in, wen, ren, clr_err,
`ifdef RING_FIFO_AFULL_EN
    input  almost_full,
`endif
    input  out, available, full, empty, count, overflow, underflow
  );

  modport slave (
    input  in, wen, ren, clr_err,
`ifdef RING_FIFO_AFULL_EN
    output almost_full,
`endif
    output out, available, full, empty, count, overflow, underflow
  );

endinterface

`default_nettype wire

// File: rtl/ring_fifo_mem.sv
// ring_fifo_mem -- DATA_W x 2**ADDR_W simple dual-port RAM, registered read, no reset | rev 1.0
`default_nettype none

module ring_fifo_mem
  import ring_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = c_data_w,
  parameter int unsigned ADDR_W = c_addr_w
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] wr_addr,
  input  wire logic [DATA_W-1:0] wr_data,
  input  wire logic              re,
  input  wire logic [ADDR_W-1:0] rd_addr,
  output logic      [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Read-before-write: a pop and push on the same slot returns the old word.
  always_ff @(posedge clk) begin
    if (we) r_mem[wr_addr] <= wr_data;
    if (re) r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/ring_fifo.sv
// ring_fifo -- parametrised ring buffer with status and sticky error flags;
// optional almost_full output under RING_FIFO_AFULL_EN | rev 1.0
`default_nettype none

module ring_fifo
  import ring_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = c_data_w,
  parameter int unsigned ADDR_W = c_addr_w
`ifdef RING_FIFO_AFULL_EN
  , parameter int unsigned AFULL_LVL = fifo_depth(ADDR_W) - 2
`endif
) (
  input wire logic   clk,
  input wire logic   rst,
  ring_fifo_if.slave bus
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);
  localparam int unsigned PTR_W = ptr_width(ADDR_W);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic              r_available;
  logic              r_overflow;
  logic              r_underflow;
  logic              r_out_loaded;
  logic [PTR_W-1:0]  w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic [DATA_W-1:0] w_rd_data;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == PTR_W'(DEPTH));
  assign w_pop   = bus.ren && !w_empty;
  assign w_push  = bus.wen && (!w_full || w_pop);

  ring_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we      (w_push),
    .wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .wr_data (bus.in),
    .re      (w_pop),
    .rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_available  <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_out_loaded <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_available  <= w_pop;
      r_out_loaded <= r_out_loaded | w_pop;
      // A fresh error event outranks a clear in the same cycle.
      if (bus.wen && !w_push)     r_overflow <= 1'b1;
      else if (bus.clr_err)       r_overflow <= 1'b0;
      if (bus.ren && w_empty)     r_underflow <= 1'b1;
      else if (bus.clr_err)       r_underflow <= 1'b0;
    end
  end

`ifdef RING_FIFO_AFULL_EN
  logic             r_almost_full;
  logic [PTR_W-1:0] w_count_next;

  always_comb begin
    w_count_next = w_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = w_count + PTR_W'(1);
      2'b01:   w_count_next = w_count - PTR_W'(1);
      default: w_count_next = w_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_almost_full <= 1'b0;
    else     r_almost_full <= (w_count_next >= PTR_W'(AFULL_LVL));
  end

  assign bus.almost_full = r_almost_full;
`endif

  // The RAM read register has no reset, so out is forced to 0 until the first pop.
  assign bus.out       = r_out_loaded ? w_rd_data : '0;
  assign bus.available = r_available;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.count     = w_count;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_ring_fifo.sv
// tb_ring_fifo -- randomized and directed checks of ring_fifo against a queue model | rev 1.0
`default_nettype none

module tb_ring_fifo;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AFULL  = DEPTH - 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ring_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ring_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] q [$];
  logic [7:0] exp_out   = 8'h00;
  logic       exp_avail = 1'b0;
  logic       exp_ovf   = 1'b0;
  logic       exp_unf   = 1'b0;
  int         n_checks  = 0;
  int         n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string ph);
    check({ph, ".out"},       32'(bus.out),       32'(exp_out));
    check({ph, ".available"}, 32'(bus.available), 32'(exp_avail));
    check({ph, ".count"},     32'(bus.count),     q.size());
    check({ph, ".empty"},     32'(bus.empty),     32'(q.size() == 0));
    check({ph, ".full"},      32'(bus.full),      32'(q.size() == DEPTH));
    check({ph, ".overflow"},  32'(bus.overflow),  32'(exp_ovf));
    check({ph, ".underflow"}, 32'(bus.underflow), 32'(exp_unf));
`ifdef RING_FIFO_AFULL_EN
    check({ph, ".almost_full"}, 32'(bus.almost_full), 32'(q.size() >= AFULL));
`endif
  endtask

  // One clock: the model decides from its pre-edge state, then the DUT is sampled 1ns after the edge.
  task automatic step(input string ph, input logic w, input logic r, input logic [7:0] d, input logic clr);
    bit pop, push;
    bus.wen = w; bus.ren = r; bus.in = d; bus.clr_err = clr;
    pop  = r && (q.size() != 0);
    push = w && (q.size() < DEPTH || pop);
    if (pop)  exp_out = q.pop_front();
    if (push) q.push_back(d);
    exp_avail = pop;
    if (w && !push)  exp_ovf = 1'b1;
    else if (clr)    exp_ovf = 1'b0;
    if (r && !pop)   exp_unf = 1'b1;
    else if (clr)    exp_unf = 1'b0;
    @(posedge clk);
    #1;
    bus.wen = 1'b0; bus.ren = 1'b0; bus.clr_err = 1'b0;
    check_outputs(ph);
  endtask

  initial begin
    int pushes;
    logic [7:0] smoke [3];
    smoke[0] = 8'h31; smoke[1] = 8'h32; smoke[2] = 8'h2B;
    bus.in = '0; bus.wen = 1'b0; bus.ren = 1'b0; bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs("reset");

    for (int i = 0; i < 3; i++) step("smoke_wr", 1'b1, 1'b0, smoke[i], 1'b0);
    for (int i = 0; i < 3; i++) step("smoke_rd", 1'b0, 1'b1, 8'h00, 1'b0);

    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 8'(i), 1'b0);
    step("drop", 1'b1, 1'b0, 8'hAA, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 8'h00, 1'b0);

    step("empty_rd", 1'b0, 1'b1, 8'h00, 1'b0);
    step("clr_err", 1'b0, 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    step("full_rw", 1'b1, 1'b1, 8'h55, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 1'b1, 8'h00, 1'b0);

    step("empty_rw", 1'b1, 1'b1, 8'h77, 1'b0);
    step("empty_rw_rd", 1'b0, 1'b1, 8'h00, 1'b0);
    step("clr_both", 1'b1, 1'b1, 8'h5A, 1'b1);

    pushes = 0;
    for (int i = 0; i < 800 && pushes < 48; i++) begin
      logic w, r, clr;
      logic [7:0] d;
      bit wr_heavy;
      wr_heavy = ((i / 8) % 2) == 0;
      w   = wr_heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r   = wr_heavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      d   = 8'($urandom);
      clr = ($urandom_range(0, 31) == 0);
      if (w && (q.size() < DEPTH || (r && q.size() != 0))) pushes++;
      step("rand", w, r, d, clr);
    end
    check("rand.push_budget", 32'(pushes >= 48), 32'd1);

    step("pre_rst_a", 1'b1, 1'b0, 8'hC3, 1'b0);
    step("pre_rst_b", 1'b1, 1'b0, 8'hC4, 1'b0);
    step("pre_rst_rw", 1'b1, 1'b1, 8'hC5, 1'b0);
    rst = 1'b1;
    #1;
    q.delete();
    exp_out = 8'h00; exp_avail = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs("post_rst");
    step("post_rst_rd", 1'b0, 1'b1, 8'h00, 1'b0);
    step("post_rst_wr", 1'b1, 1'b0, 8'h9E, 1'b0);
    step("post_rst_rd2", 1'b0, 1'b1, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
